// File: rtl/amiq_csv_encoder.sv
// amiq_csv_encoder: converts unsigned samples into an ASCII decimal byte
// stream "v0,v1,...,vN-1". Each sample is converted with a bit-serial
// double-dabble, then its digits are emitted most-significant first with
// leading zeros suppressed. A separator follows every value except the last
// one of a message, whose final digit carries m_last.
module amiq_csv_encoder #(
    parameter int         DATA_W     = 16,
    parameter int         NOF_VALUES = 20,
    parameter int         DIGITS     = 5,
    parameter logic [7:0] DELIM      = 8'h2C
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [7:0]                        m_byte,
    output logic                              m_last,
    output logic [$clog2(NOF_VALUES+1)-1:0]   val_cnt
);

    localparam int CNT_W = $clog2(NOF_VALUES + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL   = (64'd1 << DATA_W) - 64'd1;
    localparam logic [63:0] DEC_RANGE = pow10(DIGITS);

    // The BCD register must be wide enough for the largest sample value.
    if (DEC_RANGE <= MAX_VAL) begin : g_digits_check
        $error("amiq_csv_encoder: DIGITS too small for DATA_W");
    end

    if (NOF_VALUES < 1) begin : g_nof_check
        $error("amiq_csv_encoder: NOF_VALUES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT,
        SEP
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] shreg;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_step;
    logic [BIT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        cur_digit;
    logic              conv_done;
    logic              last_val;

    // One double-dabble step: correct every digit >= 5, then shift in a bit.
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic in_bit);
        logic [BCD_W-1:0] t;
        t = b;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[4*d +: 4] >= 4'd5) begin
                t[4*d +: 4] = t[4*d +: 4] + 4'd3;
            end
        end
        return {t[BCD_W-2:0], in_bit};
    endfunction

    // Index of the most-significant nonzero digit; zero when the value is zero.
    function automatic logic [IDX_W-1:0] msd(input logic [BCD_W-1:0] b);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (b[4*d +: 4] != 4'd0) begin
                r = IDX_W'(d);
            end
        end
        return r;
    endfunction

    assign bcd_step  = dabble(bcd, shreg[DATA_W-1]);
    assign conv_done = (bit_cnt == BIT_W'(DATA_W - 1));
    assign last_val  = (val_cnt == CNT_W'(NOF_VALUES - 1));
    assign s_ready   = (state == IDLE);

    // Select the digit currently being emitted.
    always_comb begin
        cur_digit = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                cur_digit = bcd[4*d +: 4];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and output stream bytes; clr overrides every handshake.
    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        m_byte     = 8'h00;
        m_last     = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                m_byte  = 8'h30 + {4'h0, cur_digit};
                m_last  = (idx == '0) && last_val;
                if (m_ready && (idx == '0)) begin
                    state_next = last_val ? IDLE : SEP;
                end
            end
            SEP: begin
                m_valid = 1'b1;
                m_byte  = DELIM;
                if (m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clr) begin
            state_next = IDLE;
        end
    end

    // Datapath: sample capture, conversion, digit walk and message counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            val_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
            idx     <= '0;
            val_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        shreg   <= s_data;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    bcd     <= bcd_step;
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (conv_done) begin
                        idx <= msd(bcd_step);
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (idx != '0) begin
                            idx <= idx - IDX_W'(1);
                        end else if (last_val) begin
                            val_cnt <= '0;
                        end else begin
                            val_cnt <= val_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amiq_csv_encoder.sv
// Testbench for amiq_csv_encoder: random samples against a decimal-string
// reference model, with a monitor collecting every transferred byte.
module tb_amiq_csv_encoder;

    localparam int DATA_W = 16;
    localparam int NOF    = 3;
    localparam int CNT_W  = $clog2(NOF + 1);

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [7:0]        m_byte;
    logic              m_last;
    logic [CNT_W-1:0]  val_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [CNT_W-1:0] vc_seq[$];
    logic [CNT_W-1:0] prev_val = '0;
    int  msg_pos   = 0;
    int  last_cnt  = 0;
    bit  ready_rand = 0;
    bit  hold_chk  = 0;
    logic [7:0] held_byte;
    logic       held_last;

    amiq_csv_encoder #(
        .DATA_W(DATA_W),
        .NOF_VALUES(NOF),
        .DIGITS(5),
        .DELIM(8'h2C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_byte(m_byte),
        .m_last(m_last),
        .val_cnt(val_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: always 1 or a 50% coin flip each cycle.
    always @(posedge clk) begin
        #1;
        m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: collect transferred bytes, check stall stability, track val_cnt.
    always @(negedge clk) begin
        if (val_cnt !== prev_val) begin
            vc_seq.push_back(val_cnt);
            prev_val = val_cnt;
        end
        if (rst_n && !clr) begin
            if (hold_chk) begin
                n_vec++;
                if (m_valid !== 1'b1 || m_byte !== held_byte || m_last !== held_last) begin
                    n_err++;
                    $display("[TB] FAIL stall_stable: got v=%b byte=%h last=%b, expected v=1 byte=%h last=%b",
                             m_valid, m_byte, m_last, held_byte, held_last);
                end
            end
            if (m_valid && m_ready) begin
                got_q.push_back({m_last, m_byte});
                if (m_last) last_cnt++;
            end
            hold_chk  = m_valid && !m_ready;
            held_byte = m_byte;
            held_last = m_last;
        end else begin
            hold_chk = 0;
        end
    end

    // Reference model: decimal text of each accepted value plus message framing.
    function automatic void model_push(input int unsigned v);
        byte unsigned d[$];
        int unsigned  t;
        t = v;
        do begin
            d.push_front(byte'(8'h30 + t % 10));
            t = t / 10;
        end while (t != 0);
        foreach (d[i]) begin
            exp_q.push_back({((i == d.size() - 1) && (msg_pos == NOF - 1)), d[i]});
        end
        if (msg_pos != NOF - 1) exp_q.push_back({1'b0, 8'h2C});
        msg_pos = (msg_pos + 1) % NOF;
    endfunction

    function automatic int unsigned rand_val();
        int unsigned r;
        r = $urandom_range(0, 65535);
        return r >> $urandom_range(0, 16);
    endfunction

    // Offer one sample and hold it until the encoder accepts it.
    task automatic send_sample(input int unsigned v);
        bit acc;
        s_data  = DATA_W'(v);
        s_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready && !clr && rst_n;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (acc) begin
            model_push(v);
        end else begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept of %0d", v);
        end
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (got_q.size() >= n) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
        msg_pos = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_byte !== 8'h00) begin n_err++; $display("[TB] FAIL reset_m_byte: got %h expected 00", m_byte); end
        n_vec++; if (m_last !== 1'b0) begin n_err++; $display("[TB] FAIL reset_m_last: got %b expected 0", m_last); end
        n_vec++; if (val_cnt !== '0) begin n_err++; $display("[TB] FAIL reset_val_cnt: got %0d expected 0", val_cnt); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [8:0] ref1[9];
        bit ok;
        bit hs;
        int n;
        ref1 = '{9'h030, 9'h02C, 9'h037, 9'h02C, 9'h036, 9'h035, 9'h035, 9'h033, 9'h135};
        ready_rand = 0;
        clear_queues();
        send_sample(0);
        n = 0;
        hs = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = m_valid && m_ready;
            @(posedge clk);
            n++;
        end
        #1;
        n_vec++; if (n != DATA_W + 1) begin n_err++; $display("[TB] FAIL latency: got %0d edges expected %0d", n, DATA_W + 1); end
        send_sample(7);
        send_sample(65535);
        wait_bytes(9, ok);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (!ok || got_q.size() != 9) begin n_err++; $display("[TB] FAIL basic_count: got %0d bytes expected 9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== ref1[i]) begin n_err++; $display("[TB] FAIL basic_byte[%0d]: got %h expected %h", i, got_q[i], ref1[i]); end
        end
        clear_queues();
    endtask

    task automatic test_stall();
        bit ok;
        ready_rand = 1;
        clear_queues();
        send_sample(0);
        send_sample(7);
        send_sample(65535);
        wait_bytes(exp_q.size(), ok);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL stall_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL stall_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        ready_rand = 0;
        clear_queues();
    endtask

    task automatic test_internal_zeros();
        logic [8:0] ref3[8];
        bit ok;
        ref3 = '{9'h031, 9'h030, 9'h030, 9'h02C, 9'h031, 9'h030, 9'h02C, 9'h133};
        clear_queues();
        send_sample(100);
        send_sample(10);
        send_sample(3);
        wait_bytes(8, ok);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (!ok || got_q.size() != 8) begin n_err++; $display("[TB] FAIL zeros_count: got %0d bytes expected 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== ref3[i]) begin n_err++; $display("[TB] FAIL zeros_byte[%0d]: got %h expected %h", i, got_q[i], ref3[i]); end
        end
        clear_queues();
    endtask

    task automatic test_clr();
        bit ok;
        ready_rand = 0;
        clear_queues();
        send_sample(5);
        send_sample(4821);
        wait_bytes(3, ok);
        n_vec++; if (!ok || m_valid !== 1'b1 || m_byte !== 8'h38) begin n_err++; $display("[TB] FAIL clr_pre_byte: got v=%b byte=%h expected v=1 byte=38", m_valid, m_byte); end
        n_vec++; if (val_cnt !== CNT_W'(1)) begin n_err++; $display("[TB] FAIL clr_pre_cnt: got %0d expected 1", val_cnt); end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL clr_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (val_cnt !== '0) begin n_err++; $display("[TB] FAIL clr_val_cnt: got %0d expected 0", val_cnt); end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL clr_s_ready: got %b expected 1", s_ready); end
        n_vec++; if (got_q.size() != 3) begin n_err++; $display("[TB] FAIL clr_prefix_count: got %0d bytes expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL clr_prefix[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_queues();
        for (int k = 0; k < NOF; k++) send_sample(rand_val());
        wait_bytes(exp_q.size(), ok);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL clr_after_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL clr_after_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_queues();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_queues();
        send_sample(rand_val());
        wait_bytes(exp_q.size(), ok);
        send_sample(rand_val());
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (val_cnt !== CNT_W'(1)) begin n_err++; $display("[TB] FAIL rstmid_pre_cnt: got %0d expected 1", val_cnt); end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_last !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_m_last: got %b expected 0", m_last); end
        n_vec++; if (val_cnt !== '0) begin n_err++; $display("[TB] FAIL rstmid_val_cnt: got %0d expected 0", val_cnt); end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_s_ready: got %b expected 1", s_ready); end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_queues();
        for (int k = 0; k < NOF; k++) send_sample(rand_val());
        wait_bytes(exp_q.size(), ok);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL rstmid_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL rstmid_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [CNT_W-1:0] ref6[7];
        ref6 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        ready_rand = 1;
        clear_queues();
        last_cnt = 0;
        vc_seq.delete();
        vc_seq.push_back('0);
        for (int k = 0; k < 2 * NOF; k++) send_sample(rand_val());
        wait_bytes(exp_q.size(), ok);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL b2b_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL b2b_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (last_cnt != 2) begin n_err++; $display("[TB] FAIL b2b_last_pulses: got %0d expected 2", last_cnt); end
        n_vec++; if (vc_seq.size() != 7) begin n_err++; $display("[TB] FAIL b2b_cnt_len: got %0d expected 7", vc_seq.size()); end
        for (int i = 0; i < 7 && i < vc_seq.size(); i++) begin
            n_vec++;
            if (vc_seq[i] !== ref6[i]) begin n_err++; $display("[TB] FAIL b2b_cnt_seq[%0d]: got %0d expected %0d", i, vc_seq[i], ref6[i]); end
        end
        ready_rand = 0;
        clear_queues();
    endtask

    task automatic test_random();
        bit ok;
        ready_rand = 1;
        clear_queues();
        send_sample(65535);
        send_sample(0);
        for (int k = 0; k < 3 * NOF + 1; k++) send_sample(rand_val());
        wait_bytes(exp_q.size(), ok);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL random_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL random_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        ready_rand = 0;
        clear_queues();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_internal_zeros();
        test_clr();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
